// File: rtl/facelet_sampler_if.sv
// Bus between the camera/display side and facelet_sampler: pixel stream,
// capture request, facelet read port and status flags.
interface facelet_sampler_if;
    logic       Capture;
    logic [2:0] Face;
    logic       frame_start;
    logic       pix_valid;
    logic [9:0] pix_X;
    logic [9:0] pix_Y;
    logic [7:0] pix_R;
    logic [7:0] pix_G;
    logic [7:0] pix_B;
    logic [5:0] rd_addr;
    logic [2:0] rd_color;
    logic       Busy;
    logic       Done;
    logic       Err;

    modport master (
        output Capture, Face, frame_start, pix_valid, pix_X, pix_Y,
               pix_R, pix_G, pix_B, rd_addr,
        input  rd_color, Busy, Done, Err
    );

    modport slave (
        input  Capture, Face, frame_start, pix_valid, pix_X, pix_Y,
               pix_R, pix_G, pix_B, rd_addr,
        output rd_color, Busy, Done, Err
    );
endinterface

// File: rtl/facelet_sampler.sv
// Samples nine grid windows of one camera frame, classifies each average into a
// cube colour and stores it in a 54-entry facelet memory read by the VGA painter.
//
// state      | meaning
// S_IDLE     | waiting for Capture
// S_ARM      | waiting for the first pixel of a frame
// S_ACCUM    | summing window pixels until the next frame_start
// S_CLASSIFY | one sticker per cycle, k = 0..8, written to memory
// S_DONE     | one-cycle completion pulse
module facelet_sampler #(
    parameter int GRID_X0 = 200,
    parameter int GRID_Y0 = 120,
    parameter int CUBE_S  = 80,
    parameter int WIN     = 8
) (
    input logic             Clk,
    input logic             Reset,
    facelet_sampler_if.slave bus
);

    localparam int LOG_W = $clog2(WIN);
    localparam int ACC_W = 8 + 2 * LOG_W;

    typedef logic [ACC_W-1:0] acc_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_ACCUM,
        S_CLASSIFY,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] face_q, face_d;
    logic [3:0] k_q, k_d;
    logic       err_q, err_d;
    logic [2:0] rd_color_q, rd_color_d;
    logic [2:0] mem_q [54];
    logic [2:0] mem_d [54];
    acc_t       sum_r_q [9];
    acc_t       sum_r_d [9];
    acc_t       sum_g_q [9];
    acc_t       sum_g_d [9];
    acc_t       sum_b_q [9];
    acc_t       sum_b_d [9];

    logic [2:0] col_hit, row_hit;
    logic [8:0] win_hit;
    logic       accum_en, clear_en;
    logic [5:0] wr_addr;
    logic [7:0] avg_r, avg_g, avg_b;
    logic [2:0] cls;

    function automatic logic [9:0] win_lo(input int origin, input int idx);
        return 10'(origin + idx * CUBE_S + CUBE_S / 2 - WIN / 2);
    endfunction

    function automatic acc_t sat_add(input acc_t acc, input logic [7:0] pix);
        logic [ACC_W:0] s;
        s = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, pix};
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    // Rules in priority order; 10-bit intermediates keep 4*255 from wrapping.
    function automatic logic [2:0] classify(input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b);
        logic [9:0] r10, g10, b10, mx, mn;
        logic [2:0] c;
        r10 = {2'b00, r};
        g10 = {2'b00, g};
        b10 = {2'b00, b};
        mx  = (r10 > g10) ? r10 : g10;
        mx  = (b10 > mx) ? b10 : mx;
        mn  = (r10 < g10) ? r10 : g10;
        mn  = (b10 < mn) ? b10 : mn;
        if (mn >= 10'd150 && (mx - mn) < 10'd40) begin
            c = 3'd0;
        end else if (r10 >= g10 && r10 >= b10) begin
            if ((g10 << 2) >= (r10 + (r10 << 1)))  c = 3'd1;
            else if ((g10 << 1) >= r10)            c = 3'd3;
            else                                   c = 3'd2;
        end else if (g10 > r10 && g10 >= b10) begin
            if ((r10 << 2) >= (g10 + (g10 << 1)))  c = 3'd1;
            else                                   c = 3'd4;
        end else begin
            c = 3'd5;
        end
        return c;
    endfunction

    always_comb begin
        col_hit = '0;
        row_hit = '0;
        win_hit = '0;
        for (int i = 0; i < 3; i++) begin
            col_hit[i] = (bus.pix_X >= win_lo(GRID_X0, i)) &&
                         (bus.pix_X <= win_lo(GRID_X0, i) + 10'(WIN - 1));
            row_hit[i] = (bus.pix_Y >= win_lo(GRID_Y0, i)) &&
                         (bus.pix_Y <= win_lo(GRID_Y0, i) + 10'(WIN - 1));
        end
        for (int k = 0; k < 9; k++) begin
            win_hit[k] = row_hit[k / 3] & col_hit[k % 3];
        end
    end

    assign wr_addr = 6'(face_q) * 6'd9 + 6'(k_q);
    assign avg_r   = sum_r_q[k_q][ACC_W-1 -: 8];
    assign avg_g   = sum_g_q[k_q][ACC_W-1 -: 8];
    assign avg_b   = sum_b_q[k_q][ACC_W-1 -: 8];
    assign cls     = classify(avg_r, avg_g, avg_b);

    always_comb begin
        state_d  = state_q;
        face_d   = face_q;
        k_d      = k_q;
        err_d    = 1'b0;
        mem_d    = mem_q;
        accum_en = 1'b0;
        clear_en = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.Capture) begin
                    if (bus.Face <= 3'd5) begin
                        face_d   = bus.Face;
                        clear_en = 1'b1;
                        state_d  = S_ARM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_ARM: begin
                if (bus.frame_start && bus.pix_valid) begin
                    accum_en = 1'b1;
                    state_d  = S_ACCUM;
                end
            end
            S_ACCUM: begin
                // The pixel carrying the next frame_start belongs to the next frame.
                if (bus.frame_start) begin
                    k_d     = 4'd0;
                    state_d = S_CLASSIFY;
                end else if (bus.pix_valid) begin
                    accum_en = 1'b1;
                end
            end
            S_CLASSIFY: begin
                mem_d[wr_addr] = cls;
                if (k_q == 4'd8) begin
                    state_d = S_DONE;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        sum_r_d = sum_r_q;
        sum_g_d = sum_g_q;
        sum_b_d = sum_b_q;
        for (int k = 0; k < 9; k++) begin
            if (clear_en) begin
                sum_r_d[k] = '0;
                sum_g_d[k] = '0;
                sum_b_d[k] = '0;
            end else if (accum_en && win_hit[k]) begin
                sum_r_d[k] = sat_add(sum_r_q[k], bus.pix_R);
                sum_g_d[k] = sat_add(sum_g_q[k], bus.pix_G);
                sum_b_d[k] = sat_add(sum_b_q[k], bus.pix_B);
            end
        end
    end

    // Reads mem_q, so a same-cycle write is seen one edge later.
    always_comb begin
        rd_color_d = 3'd7;
        if (bus.rd_addr <= 6'd53) begin
            rd_color_d = mem_q[bus.rd_addr];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            face_q     <= '0;
            k_q        <= '0;
            err_q      <= 1'b0;
            rd_color_q <= 3'd7;
            for (int i = 0; i < 54; i++) begin
                mem_q[i] <= 3'd7;
            end
            for (int k = 0; k < 9; k++) begin
                sum_r_q[k] <= '0;
                sum_g_q[k] <= '0;
                sum_b_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            face_q     <= face_d;
            k_q        <= k_d;
            err_q      <= err_d;
            rd_color_q <= rd_color_d;
            mem_q      <= mem_d;
            sum_r_q    <= sum_r_d;
            sum_g_q    <= sum_g_d;
            sum_b_q    <= sum_b_d;
        end
    end

    assign bus.rd_color = rd_color_q;
    assign bus.Busy     = (state_q == S_ARM) || (state_q == S_ACCUM) ||
                          (state_q == S_CLASSIFY);
    assign bus.Done     = (state_q == S_DONE);
    assign bus.Err      = err_q;

endmodule

// File: tb/tb_facelet_sampler.sv
// Self-checking bench for facelet_sampler: a window/colour model feeds a queue of
// expected facelet colours that is drained when the memory is read back.
module tb_facelet_sampler;

    logic Clk = 1'b0;
    logic Reset = 1'b1;

    always #5 Clk = ~Clk;

    facelet_sampler_if bus();

    facelet_sampler dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [2:0] exp_mem [54];
    logic [2:0] exp_q [$];
    int sum_r [9];
    int sum_g [9];
    int sum_b [9];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    function automatic int win_of(input int x, input int y);
        for (int k = 0; k < 9; k++) begin
            int cx, cy;
            cx = 200 + (k % 3) * 80 + 40;
            cy = 120 + (k / 3) * 80 + 40;
            if (x >= cx - 4 && x <= cx + 3 && y >= cy - 4 && y <= cy + 3) return k;
        end
        return -1;
    endfunction

    function automatic int ref_class(input int r, input int g, input int b);
        int mx, mn;
        mx = (r > g) ? r : g;  mx = (b > mx) ? b : mx;
        mn = (r < g) ? r : g;  mn = (b < mn) ? b : mn;
        if (mn >= 150 && mx - mn < 40) return 0;
        if (r >= g && r >= b) return (4 * g >= 3 * r) ? 1 : ((2 * g >= r) ? 3 : 2);
        if (g > r && g >= b) return (4 * r >= 3 * g) ? 1 : 4;
        return 5;
    endfunction

    function automatic int sat(input int v);
        return (v > 16383) ? 16383 : v;
    endfunction

    task automatic model_add(input int x, input int y, input int r, input int g, input int b);
        int k;
        k = win_of(x, y);
        if (k >= 0) begin
            sum_r[k] = sat(sum_r[k] + r);
            sum_g[k] = sat(sum_g[k] + g);
            sum_b[k] = sat(sum_b[k] + b);
        end
    endtask

    task automatic drive(input bit fs, input bit vld, input int x, input int y,
                         input int r, input int g, input int b);
        @(negedge Clk);
        bus.frame_start = fs;
        bus.pix_valid   = vld;
        bus.pix_X = 10'(x);  bus.pix_Y = 10'(y);
        bus.pix_R = 8'(r);   bus.pix_G = 8'(g);  bus.pix_B = 8'(b);
    endtask

    task automatic pix(input int x, input int y, input int r, input int g, input int b);
        drive(1'b0, 1'b1, x, y, r, g, b);
        model_add(x, y, r, g, b);
    endtask

    task automatic start_frame(input int x, input int y, input int r, input int g, input int b);
        drive(1'b1, 1'b1, x, y, r, g, b);
        model_add(x, y, r, g, b);
    endtask

    task automatic fill_win(input int k, input int r, input int g, input int b, input int n);
        int cx, cy;
        cx = 200 + (k % 3) * 80 + 40;
        cy = 120 + (k / 3) * 80 + 40;
        for (int i = 0; i < n; i++) pix(cx - 4 + (i % 8), cy - 4 + ((i / 8) % 8), r, g, b);
    endtask

    task automatic begin_capture(input int face);
        for (int k = 0; k < 9; k++) begin
            sum_r[k] = 0; sum_g[k] = 0; sum_b[k] = 0;
        end
        @(negedge Clk);
        bus.Capture = 1'b1;
        bus.Face    = 3'(face);
        @(negedge Clk);
        bus.Capture = 1'b0;
        check("busy_arm", bus.Busy, 1);
        // Window pixel while still armed: must not be summed.
        drive(1'b0, 1'b1, 240, 160, 0, 0, 255);
    endtask

    task automatic finish_capture(input int face, input bit coll);
        int lat;
        logic [2:0] old31;
        old31 = exp_mem[31];
        for (int k = 0; k < 9; k++) begin
            logic [2:0] e;
            e = 3'(ref_class(sum_r[k] >> 6, sum_g[k] >> 6, sum_b[k] >> 6));
            exp_q.push_back(e);
            exp_mem[face * 9 + k] = e;
        end
        // Ending frame_start pixel lies in window 0 but must not be summed.
        drive(1'b1, 1'b1, 240, 160, 0, 0, 255);
        if (coll) bus.rd_addr = 6'd31;
        lat = 99;
        for (int n = 1; n <= 20; n++) begin
            @(negedge Clk);
            if (n == 1) begin
                bus.frame_start = 1'b0;
                bus.pix_valid   = 1'b0;
            end
            if (n == 5) check("busy_classify", bus.Busy, 1);
            if (coll && n == 6) check("coll_old", bus.rd_color, old31);
            if (coll && n == 7) check("coll_new", bus.rd_color, exp_mem[31]);
            if (bus.Done) begin
                lat = n;
                break;
            end
        end
        check("done_lat", lat, 10);
        check("busy_at_done", bus.Busy, 0);
        @(negedge Clk);
        check("done_pulse", bus.Done, 0);
    endtask

    task automatic read_all(input int face);
        for (int a = 0; a < 54; a++) begin
            logic [2:0] e;
            @(negedge Clk);
            bus.rd_addr = 6'(a);
            @(negedge Clk);
            e = exp_mem[a];
            if (face >= 0 && a / 9 == face) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
            end
            check($sformatf("mem[%0d]", a), bus.rd_color, e);
        end
        @(negedge Clk);
        bus.rd_addr = 6'd54;
        @(negedge Clk);
        check("rd_oor54", bus.rd_color, 7);
        bus.rd_addr = 6'd63;
        @(negedge Clk);
        check("rd_oor63", bus.rd_color, 7);
    endtask

    initial begin
        int lat;
        bus.Capture = 1'b0;  bus.Face = 3'd0;
        bus.frame_start = 1'b0;  bus.pix_valid = 1'b0;
        bus.pix_X = '0;  bus.pix_Y = '0;
        bus.pix_R = '0;  bus.pix_G = '0;  bus.pix_B = '0;
        bus.rd_addr = 6'd0;
        for (int a = 0; a < 54; a++) exp_mem[a] = 3'd7;

        repeat (2) @(negedge Clk);
        check("rst_busy", bus.Busy, 0);
        check("rst_done", bus.Done, 0);
        check("rst_err", bus.Err, 0);
        check("rst_rd", bus.rd_color, 7);
        Reset = 1'b0;

        // Uniform white on face U; sticker 8 gets 65 pixels to force saturation.
        begin_capture(0);
        start_frame(0, 0, 255, 255, 255);
        for (int k = 0; k < 9; k++) fill_win(k, 255, 255, 255, (k == 8) ? 65 : 64);
        pix(100, 100, 255, 255, 255);
        pix(400, 300, 255, 255, 255);
        finish_capture(0, 1'b0);
        read_all(0);

        // Illegal face: Err pulse only.
        @(negedge Clk);
        bus.Capture = 1'b1;
        bus.Face    = 3'd6;
        @(negedge Clk);
        bus.Capture = 1'b0;
        check("err_pulse", bus.Err, 1);
        check("err_busy", bus.Busy, 0);
        @(negedge Clk);
        check("err_clear", bus.Err, 0);
        check("err_busy2", bus.Busy, 0);
        read_all(-1);

        // Face F colour set, a stray Capture mid-frame and a read collision on 31.
        begin_capture(3);
        start_frame(0, 0, 0, 0, 0);
        fill_win(0, 250, 240, 10, 64);
        fill_win(1, 200, 40, 30, 64);
        fill_win(2, 230, 130, 20, 64);
        fill_win(3, 20, 200, 40, 64);
        @(negedge Clk);
        bus.pix_valid = 1'b0;
        bus.Capture   = 1'b1;
        bus.Face      = 3'd0;
        @(negedge Clk);
        bus.Capture = 1'b0;
        check("busy_mid", bus.Busy, 1);
        check("err_mid", bus.Err, 0);
        fill_win(4, 20, 40, 200, 64);
        fill_win(5, 240, 240, 240, 64);
        fill_win(6, 20, 40, 200, 64);
        fill_win(7, 20, 200, 40, 64);
        fill_win(8, 200, 40, 30, 64);
        finish_capture(3, 1'b1);
        read_all(3);

        // Sticker 0 window edges on face R; the start pixel is the top-left corner.
        begin_capture(5);
        start_frame(236, 156, 192, 0, 0);
        pix(243, 163, 0, 128, 0);
        pix(235, 156, 0, 0, 255);
        pix(244, 163, 0, 0, 255);
        pix(239, 155, 0, 0, 255);
        pix(239, 164, 0, 0, 255);
        finish_capture(5, 1'b0);
        read_all(5);

        // Reset after four classify writes.
        begin_capture(1);
        start_frame(0, 0, 0, 0, 0);
        for (int k = 0; k < 9; k++) fill_win(k, 20, 200, 40, 64);
        drive(1'b1, 1'b1, 0, 0, 0, 0, 0);
        lat = 0;
        for (int n = 1; n <= 5; n++) begin
            @(negedge Clk);
            if (n == 1) begin
                bus.frame_start = 1'b0;
                bus.pix_valid   = 1'b0;
            end
            if (n == 5) begin
                Reset = 1'b1;
                lat   = n;
            end
        end
        #1;
        check("rr_reached", lat, 5);
        check("rr_busy", bus.Busy, 0);
        check("rr_done", bus.Done, 0);
        check("rr_err", bus.Err, 0);
        check("rr_rd", bus.rd_color, 7);
        for (int a = 0; a < 54; a++) exp_mem[a] = 3'd7;
        @(negedge Clk);
        Reset = 1'b0;
        read_all(-1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
